fifo_rptr_rempty: RTL and testbench
===================================

// Module: fifo_rptr_rempty
// PURPOSE
//  Read-domain pointer and status controller of the async FIFO. It is the read-side counterpart of the write-pointer/full block.
//  - Advances a binary read pointer and its Gray image on Rinc.
//  - Drives the dual-port RAM read address.
//  - Flags empty and almost-empty.
//  - Reports an estimated fill level and a sticky underflow error.
//  - Sits in the Rclk domain. Consumes Rq2_wptr, the write pointer after the 2-flop synchroniser.
//    Exports Rptr to the write-domain synchroniser.
// PARAMETERS
//  Address_width    3  RAM address bits; depth = 2**Address_width
//  Almost_empty_th  1  Ralmost_empty asserts when fill count <= this value (0..depth)
// PORTS
//  Rclk           in   1                read clock; all state on posedge
//  Rrst           in   1                async active-low reset
//  Rinc           in   1                read request; accepted only when ~Rempty
//  Rq2_wptr       in   Address_width+1  synchronised Gray write pointer
//  Radder         out  Address_width    RAM read address (binary, low bits)
//  Rptr           out  Address_width+1  registered Gray read pointer (to CDC sync)
//  Rempty         out  1                FIFO empty, registered
//  Ralmost_empty  out  1                fill count <= Almost_empty_th, registered
//  Rcount         out  Address_width+1  fill level seen from read side, registered
//  Rerr_underflow out  1                sticky: Rinc seen while Rempty
// BEHAVIOUR
//  Reset (Rrst=0, async, any time):
//   - rbin=0, Rptr=0, Rempty=1, Ralmost_empty=1, Rcount=0, Rerr_underflow=0.
//   - A reset mid-operation discards all pointer state immediately.
//  Pointer arithmetic:
//   - rbin is Address_width+1 bits wide and wraps modulo 2**(Address_width+1).
//   - rbin_next = rbin + (Rinc & ~Rempty).
//   - rgray_next = (rbin_next>>1) ^ rbin_next.
//   - Each edge: rbin<=rbin_next, Rptr<=rgray_next.
//   - Radder = rbin[Address_width-1:0].
//  Read latency:
//   - Radder is valid while Rempty=0. RAM data for that address is presented combinationally by the RAM.
//   - The pointer advances on the edge where Rinc & ~Rempty.
//  Empty:
//   - Rempty <= (rgray_next == Rq2_wptr).
//   - The last read sets Rempty on the same edge that advances the pointer, so there is no extra-read hazard.
//   - Deassertion follows a Rq2_wptr change by 1 Rclk.
//  Fill level:
//   - wbin_s = Gray-to-binary(Rq2_wptr), combinational.
//   - Rcount <= wbin_s - rbin_next, computed mod 2**(Address_width+1). Range 0..depth.
//   - Rcount is pessimistic: it lags writes by the synchroniser latency.
//  Ralmost_empty <= (wbin_s - rbin_next) <= Almost_empty_th.
//  Underflow:
//   - Rinc=1 while Rempty=1 is ignored; the pointer holds.
//   - Rerr_underflow <= 1 on that edge and stays 1 until reset.
//  Simultaneous Rinc and a new Rq2_wptr on one edge:
//   - Both take effect.
//   - Flags are computed from rgray_next vs the new Rq2_wptr.
//  Wrap-around:
//   - Pointer MSB toggles every depth reads.
//   - Empty compares all Address_width+1 Gray bits, so a full FIFO is never reported empty.
// STRUCTURE
//  - Shared package/include fifo_pkg: localparam DEPTH = 1<<Address_width, and the bin2gray function.
//  - The same package is used by the write-pointer block.
//  - One sub-module: fifo_gray2bin #(.W(Address_width+1)). Pure combinational XOR prefix, reused by the write side for its count.
// TESTING (Address_width=3, Almost_empty_th=1)
//  1. Reset pulse mid-run:
//     - Outputs go to Rptr=0000, Radder=0, Rempty=1, Ralmost_empty=1, Rcount=0, Rerr_underflow=0 without a clock edge.
//  2. Rq2_wptr 0000->0010 (3 entries), Rinc=0:
//     - Rempty=0 and Rcount=3 one Rclk later.
//     - Ralmost_empty=0.
//  3. Then Rinc=1 for 3 cycles:
//     - Radder 0,1,2.
//     - Rptr 0001,0011,0010.
//     - Ralmost_empty=1 after the 2nd read.
//     - Rempty=1 on the 3rd edge; a 4th Rinc leaves Rptr=0010.
//  4. The 4th Rinc while empty:
//     - Rerr_underflow=1 and stays 1 through later reads until Rrst.
//  5. Wrap: 16 write/read pairs stepping Rq2_wptr:
//     - Rptr returns to 0000 and Radder wraps 7->0.
//     - Rempty=1 at 0 fill, never at fill 8 (Rq2_wptr=1100, Rptr=0000 -> Rcount=8, Rempty=0).
//  6. Same-edge Rinc with Rq2_wptr increment at fill 1:
//     - Rempty stays 0 and Rcount stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks (read and write side).
//   ADDR_W_DEFAULT : default RAM address width
//   DEPTH          : default FIFO depth, 1 << ADDR_W_DEFAULT
//   depth()        : depth for an arbitrary address width
//   bin2gray()     : binary to reflected Gray code; callers truncate to their pointer width
package fifo_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 3;
  localparam int unsigned DEPTH          = 1 << ADDR_W_DEFAULT;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

  // Operates on a full 32-bit word so one function serves every pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the read-side empty/count logic and the write-side full/count logic.
// Ports:
//   gray : Gray-coded input, W bits
//   bin  : binary equivalent, W bits
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin        = '0;
    bin[W-1]   = gray[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/fifo_rptr_rempty.sv
// Read-domain pointer and status controller of the async FIFO.
// Keeps a binary read pointer plus its registered Gray image, drives the RAM read
// address, and derives empty / almost-empty / fill level from the synchronised
// Gray write pointer. Underflow (read while empty) is ignored and latched sticky.
// Ports:
//   Rclk           : read clock, all state on posedge
//   Rrst           : asynchronous active-low reset
//   Rinc           : read request, honoured only while Rempty is low
//   Rq2_wptr       : Gray write pointer after the 2-flop synchroniser
//   Radder         : RAM read address (low bits of the binary read pointer)
//   Rptr           : registered Gray read pointer, exported to the write domain
//   Rempty         : FIFO empty, registered
//   Ralmost_empty  : fill level <= Almost_empty_th, registered
//   Rcount         : fill level seen from the read side, registered
//   Rerr_underflow : sticky, set by Rinc while Rempty
module fifo_rptr_rempty
  import fifo_pkg::*;
#(
  parameter int unsigned Address_width   = ADDR_W_DEFAULT,
  parameter int unsigned Almost_empty_th = 1
) (
  input  logic                   Rclk,
  input  logic                   Rrst,
  input  logic                   Rinc,
  input  logic [Address_width:0] Rq2_wptr,
  output logic [Address_width-1:0] Radder,
  output logic [Address_width:0] Rptr,
  output logic                   Rempty,
  output logic                   Ralmost_empty,
  output logic [Address_width:0] Rcount,
  output logic                   Rerr_underflow
);

  localparam int unsigned PtrW = Address_width + 1;

  logic [PtrW-1:0] rbin_q,   rbin_d;
  logic [PtrW-1:0] rptr_q,   rptr_d;
  logic            rempty_q, rempty_d;
  logic            ralm_q,   ralm_d;
  logic [PtrW-1:0] rcount_q, rcount_d;
  logic            rerr_q,   rerr_d;

  logic            rd_en;
  logic [PtrW-1:0] wbin_s;
  logic [PtrW-1:0] fill_next;

  fifo_gray2bin #(
    .W (PtrW)
  ) u_wptr_g2b (
    .gray (Rq2_wptr),
    .bin  (wbin_s)
  );

  always_comb begin
    rd_en     = Rinc & ~rempty_q;
    rbin_d    = rbin_q + PtrW'(rd_en);
    rptr_d    = PtrW'(bin2gray(32'(rbin_d)));
    // Modular difference: the extra pointer bit makes a full FIFO read as DEPTH, not 0.
    fill_next = wbin_s - rbin_d;
    rcount_d  = fill_next;
    // Flags look at the post-read pointer so the last read raises empty on its own edge.
    rempty_d  = (rptr_d == Rq2_wptr);
    ralm_d    = (32'(fill_next) <= Almost_empty_th);
    rerr_d    = rerr_q | (Rinc & rempty_q);
  end

  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      ralm_q   <= 1'b1;
      rcount_q <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      ralm_q   <= ralm_d;
      rcount_q <= rcount_d;
      rerr_q   <= rerr_d;
    end
  end

  assign Radder         = rbin_q[Address_width-1:0];
  assign Rptr           = rptr_q;
  assign Rempty         = rempty_q;
  assign Ralmost_empty  = ralm_q;
  assign Rcount         = rcount_q;
  assign Rerr_underflow = rerr_q;

endmodule

// File: tb/tb_fifo_rptr_rempty.sv
module tb_fifo_rptr_rempty;

  logic       Rclk;
  logic       Rrst;
  logic       Rinc;
  logic [3:0] Rq2_wptr;
  logic [2:0] Radder;
  logic [3:0] Rptr;
  logic       Rempty;
  logic       Ralmost_empty;
  logic [3:0] Rcount;
  logic       Rerr_underflow;

  int checks   = 0;
  int failures = 0;

  fifo_rptr_rempty #(
    .Address_width   (3),
    .Almost_empty_th (1)
  ) dut (
    .Rclk           (Rclk),
    .Rrst           (Rrst),
    .Rinc           (Rinc),
    .Rq2_wptr       (Rq2_wptr),
    .Radder         (Radder),
    .Rptr           (Rptr),
    .Rempty         (Rempty),
    .Ralmost_empty  (Ralmost_empty),
    .Rcount         (Rcount),
    .Rerr_underflow (Rerr_underflow)
  );

  initial Rclk = 1'b0;
  always #5 Rclk = ~Rclk;

  // Hand-written 4-bit Gray table, independent of the RTL helper.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge Rclk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ptr, input logic [2:0] adr,
                           input logic emp, input logic alm, input logic [3:0] cnt,
                           input logic err);
    check({tag, ".Rptr"},           32'(Rptr),           32'(ptr));
    check({tag, ".Radder"},         32'(Radder),         32'(adr));
    check({tag, ".Rempty"},         32'(Rempty),         32'(emp));
    check({tag, ".Ralmost_empty"},  32'(Ralmost_empty),  32'(alm));
    check({tag, ".Rcount"},         32'(Rcount),         32'(cnt));
    check({tag, ".Rerr_underflow"}, 32'(Rerr_underflow), 32'(err));
  endtask

  initial begin
    Rrst     = 1'b0;
    Rinc     = 1'b0;
    Rq2_wptr = 4'b0000;
    #12;
    check_all("reset_init", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    Rrst = 1'b1;
    step();
    check_all("idle_empty", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);

    // Three entries arrive, no reads.
    Rq2_wptr = 4'b0010;
    step();
    check_all("fill3", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0);

    // Three reads drain it; a fourth underflows.
    Rinc = 1'b1;
    step();
    check_all("rd1", 4'b0001, 3'd1, 1'b0, 1'b0, 4'd2, 1'b0);
    step();
    check_all("rd2", 4'b0011, 3'd2, 1'b0, 1'b1, 4'd1, 1'b0);
    step();
    check_all("rd3", 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b0);
    step();
    check_all("rd4_underflow", 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b1);

    // Two more writes (wbin 5) and reads; underflow flag must stay set.
    Rinc     = 1'b0;
    Rq2_wptr = 4'b0111;
    step();
    check_all("refill2", 4'b0010, 3'd3, 1'b0, 1'b0, 4'd2, 1'b1);
    Rinc = 1'b1;
    step();
    check_all("rd5", 4'b0110, 3'd4, 1'b0, 1'b1, 4'd1, 1'b1);
    step();
    check_all("rd6", 4'b0111, 3'd5, 1'b1, 1'b1, 4'd0, 1'b1);
    Rinc     = 1'b0;
    Rq2_wptr = 4'b0101;
    step();
    check_all("pre_reset", 4'b0111, 3'd5, 1'b0, 1'b1, 4'd1, 1'b1);

    // Asynchronous reset mid-run, checked away from any clock edge.
    #2;
    Rrst = 1'b0;
    #1;
    check_all("async_reset", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    Rq2_wptr = 4'b0000;
    step();
    Rrst = 1'b1;
    step();
    check_all("post_reset", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);

    // Wrap: 16 write/read pairs.
    for (int k = 1; k <= 16; k++) begin
      Rinc     = 1'b0;
      Rq2_wptr = gray_tab[k % 16];
      step();
      check_all($sformatf("wrap_w%0d", k), gray_tab[(k - 1) % 16], 3'((k - 1) % 8),
                1'b0, 1'b1, 4'd1, 1'b0);
      Rinc = 1'b1;
      step();
      check_all($sformatf("wrap_r%0d", k), gray_tab[k % 16], 3'(k % 8),
                1'b1, 1'b1, 4'd0, 1'b0);
    end

    // Full FIFO: wbin 8 vs rbin 0 must not read as empty.
    Rinc     = 1'b0;
    Rq2_wptr = 4'b1100;
    step();
    check_all("full8", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);

    // Drain to fill 1 (seven reads).
    Rinc = 1'b1;
    repeat (7) step();
    check_all("fill1", 4'b0100, 3'd7, 1'b0, 1'b1, 4'd1, 1'b0);

    // Read and write on the same edge at fill 1.
    Rq2_wptr = 4'b1101;
    step();
    check_all("same_edge", 4'b1100, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0);
    step();
    check_all("final_drain", 4'b1101, 3'd1, 1'b1, 1'b1, 4'd0, 1'b0);
    Rinc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
